ps2_keyboard_ctrl: RTL and testbench
====================================

Name: ps2_keyboard_ctrl

Overview:
Keyboard front-end controller for the media-center SoC. Receives PS/2 device-to-host frames and buffers the scancodes in a small FIFO. Presents an Avalon-MM slave register interface to the CPU and raises a level interrupt while scancodes are pending. Replaces free-running interrupt generation with data-driven interrupts.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of 2, range 2..64.
TIMEOUT_CYCLES, 50000, clk cycles allowed between PS/2 falling edges before a partial frame is discarded (1 ms at 50 MHz).

Ports:
clk  in  1  system clock
reset_n  in  1  reset
ps2_clk  in  1  PS/2 clock from pad, asynchronous
ps2_data  in  1  PS/2 data from pad, asynchronous
s_cs_n  in  1  Avalon chip select, active-low
s_address  in  2  register select
s_read  in  1  read strobe
s_readdata  out  32  read data, zero-latency
s_write  in  1  write strobe
s_writedata  in  32  write data
irq  out  1  interrupt request, level, active-high

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All state is cleared: FIFO empty, rx FSM IDLE, sticky flags 0, irq_en 0, irq 0. s_readdata is combinational and follows the reset register contents.
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchronizer. A 4-sample shift filter on the synced clock sets the filtered level only after 4 equal samples. A falling edge is filtered 1 -> 0, one-cycle pulse. Bits are sampled from synced ps2_data on each falling edge.
- Rx FSM IDLE: on edge, if data==0 (start bit), go to DATA with bit_cnt=0. Otherwise stay in IDLE and take no other action.
- Rx FSM DATA: shift the 8 data bits in LSB first. After the 8th bit, go to PARITY.
- Rx FSM PARITY: latch the parity bit, then go to STOP.
- Rx FSM STOP: on edge, the frame is good if stop==1 and the XOR of data bits and parity is 1 (odd parity).
  - Good frame: push the byte.
  - Bad frame: discard the byte and set PERR.
  - In both cases return to IDLE.
- Timeout: the counter resets on every edge and runs in every state except IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, the partial frame is discarded, and no flag is set.
- FIFO push and pop: a push happens in the cycle after the stop edge. A pop happens when ~s_cs_n & s_read & s_address==0 and the FIFO is not empty. A read when empty returns valid=0 and does not pop.
- FIFO full: a push while full with no simultaneous pop drops the byte and sets OVF.
- Simultaneous push and pop: when full, the pop occurs first and the push is accepted with no OVF. When empty, the pop has no effect and the push is accepted.
- Register 0 DATA (R): [8] valid (FIFO not empty), [7:0] head byte; other bits 0. Writes are ignored.
- Register 1 STATUS (R/W1C): [0] not_empty, [1] full, [2] OVF sticky, [3] PERR sticky. Writing 1 to bit 2 or 3 clears that bit. If a set event and a clear occur in the same cycle, the set wins.
- Register 2 CTRL (R/W): [0] irq_en. Bit 1 is write-only: writing 1 flushes the FIFO, and the bit reads as 0.
- Register 3: reads 0; writes ignored.
- irq: registered; irq <= irq_en & not_empty. It deasserts 1 cycle after the pop that empties the FIFO or after irq_en is cleared.
- Read data mux: s_readdata = 0 whenever s_cs_n=1.

Test Plan:
- Reset check: reset with a frame half-received -> all registers read 0 (CTRL 0x0, STATUS 0x0, DATA 0x000), irq=0. The next full frame is received correctly.
- Good frame: irq_en=1, send frame for 0x1C (parity bit 0) -> STATUS=0x1 and irq=1 within 10 cycles of the stop edge. DATA read returns 0x11C. The next DATA read returns 0x000, and irq=0 one cycle after the first read.
- Bad frames:
  - 0x1C with parity 1 -> FIFO stays empty, STATUS=0x8.
  - Write 0x8 to STATUS -> STATUS=0x0.
  - Stop bit 0 -> same result as bad parity.
- Overflow: irq_en=0, send 9 frames 0x01..0x09 -> STATUS=0xF... wait, PERR stays 0, so STATUS=0x7 (full|not_empty|OVF) with irq=0. Eight reads return 0x101..0x108, then 0x000.
- Timeout: send the start bit plus 3 data bits, then idle for TIMEOUT_CYCLES+10 -> no push and no flags. A following frame 0x5A is received as 0x15A.
- Full push/pop: FIFO full, DATA read coincides with the push cycle of byte 0xAB -> no OVF, FIFO stays full, and the last entry read out is 0x1AB. Then write CTRL=0x2 -> STATUS=0x0.

Source files
------------

// File: rtl/ps2_keyboard_ctrl_if.sv
// Avalon-MM register bus between the CPU and the PS/2 keyboard controller.
interface ps2_keyboard_ctrl_if;
    logic        s_cs_n;
    logic [1:0]  s_address;
    logic        s_read;
    logic [31:0] s_readdata;
    logic        s_write;
    logic [31:0] s_writedata;

    modport master (output s_cs_n, s_address, s_read, s_write, s_writedata,
                    input  s_readdata);
    modport slave  (input  s_cs_n, s_address, s_read, s_write, s_writedata,
                    output s_readdata);
endinterface

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 device-to-host receiver with scancode FIFO, Avalon-MM registers and
// a data-driven level interrupt.
module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    ps2_keyboard_ctrl_if.slave   bus,
    output logic                 irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    // Pads are idle-high, so synchronizers and filter start high to avoid a fake edge.
    logic       clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic [3:0] clk_shift_q;
    logic       clk_filt_q;
    logic       fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_shift_q <= 4'hF;
            clk_filt_q  <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            clk_shift_q <= {clk_shift_q[2:0], clk_sync_q};
            if (clk_shift_q == 4'hF)      clk_filt_q <= 1'b1;
            else if (clk_shift_q == 4'h0) clk_filt_q <= 1'b0;
        end
    end

    assign fall = clk_filt_q & (clk_shift_q == 4'h0);

    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sr_q, sr_d;
    logic            par_q, par_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            push_q, push_d;
    logic            perr_set;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_d     = par_q;
        push_d    = 1'b0;
        perr_set  = 1'b0;
        to_cnt_d  = (fall || state_q == IDLE) ? '0 : to_cnt_q + TW'(1);
        if (fall) begin
            case (state_q)
                IDLE: if (!data_sync_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    sr_d      = {data_sync_q, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_sync_q;
                    state_d = STOP;
                end
                default: begin
                    if (data_sync_q && (^{sr_q, par_q})) push_d   = 1'b1;
                    else                                 perr_set = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE && to_cnt_q == TO_LAST) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            push_q    <= push_d;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, perr_q, perr_d, irq_en_q, irq_en_d, irq_q;
    logic          empty, full, wr_hit, pop, push_ok, ovf_set, flush;
    logic          unused_wdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign wr_hit       = ~bus.s_cs_n & bus.s_write;
    assign pop          = ~bus.s_cs_n & bus.s_read & (bus.s_address == 2'd0) & ~empty;
    assign flush        = wr_hit & (bus.s_address == 2'd2) & bus.s_writedata[1];
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok      = push_q & (~full | pop);
    assign ovf_set      = push_q & full & ~pop;
    assign unused_wdata = ^bus.s_writedata[31:4];

    always_comb begin
        count_d = count_q;
        if (flush) count_d = '0;
        else if (push_ok && !pop) count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
        ovf_d    = ovf_set  | (ovf_q  & ~(wr_hit & (bus.s_address == 2'd1) & bus.s_writedata[2]));
        perr_d   = perr_set | (perr_q & ~(wr_hit & (bus.s_address == 2'd1) & bus.s_writedata[3]));
        irq_en_d = (wr_hit && bus.s_address == 2'd2) ? bus.s_writedata[0] : irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= sr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & (count_d != '0);
        end
    end

    assign irq = irq_q;

    always_comb begin
        bus.s_readdata = '0;
        if (!bus.s_cs_n) begin
            case (bus.s_address)
                2'd0:    bus.s_readdata = {23'b0, ~empty, empty ? 8'h00 : mem[rd_ptr_q]};
                2'd1:    bus.s_readdata = {28'b0, perr_q, ovf_q, full, ~empty};
                2'd2:    bus.s_readdata = {31'b0, irq_en_q};
                default: bus.s_readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Randomized bench for ps2_keyboard_ctrl checked against a queue-based model.
module tb_ps2_keyboard_ctrl;
    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int H     = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic irq;

    ps2_keyboard_ctrl_if avl();

    ps2_keyboard_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .bus(avl), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0]  mq[$];
    bit          m_ovf, m_perr, m_irq_en;
    int          irq_lat;
    logic [31:0] coinc_rd;
    logic [31:0] rd;
    logic [31:0] exp_v;

    // Reference model: frames either enter the queue, overflow, or flag parity.
    task automatic m_frame(input logic [7:0] b, input bit good);
        if (!good) m_perr = 1'b1;
        else if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(b);
    endtask

    function automatic logic [31:0] m_data_read();
        if (mq.size() == 0) return 32'h0;
        return {23'b0, 1'b1, mq.pop_front()};
    endfunction

    function automatic logic [31:0] m_status();
        return {28'b0, m_perr, m_ovf, (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    function automatic logic m_irq();
        return m_irq_en && (mq.size() != 0);
    endfunction

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avl.s_cs_n = 1'b0; avl.s_read = 1'b1; avl.s_address = a;
        #1 d = avl.s_readdata;
        @(posedge clk);
        #1 avl.s_cs_n = 1'b1; avl.s_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] w);
        @(negedge clk);
        avl.s_cs_n = 1'b0; avl.s_write = 1'b1; avl.s_address = a; avl.s_writedata = w;
        @(posedge clk);
        #1 avl.s_cs_n = 1'b1; avl.s_write = 1'b0; avl.s_writedata = '0;
    endtask

    // coinc=1 issues a DATA read landing on the cycle the received byte is pushed.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit coinc);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        irq_lat = -1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && coinc) begin
                repeat (7) @(negedge clk);
                avl.s_cs_n = 1'b0; avl.s_read = 1'b1; avl.s_address = 2'd0;
                #1 coinc_rd = avl.s_readdata;
                @(posedge clk);
                #1 avl.s_cs_n = 1'b1; avl.s_read = 1'b0;
                repeat (H - 8) @(negedge clk);
            end else if (i == 10) begin
                for (int k = 0; k < H; k++) begin
                    @(negedge clk);
                    if (irq === 1'b1 && irq_lat < 0) irq_lat = k + 1;
                end
            end else begin
                repeat (H) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk); ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_partial(input int n, input bit wait_to);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk); ps2_data = 1'b1;
        if (wait_to) repeat (TO + 10) @(negedge clk);
    endtask

    task automatic test_reset();
        cpu_write(2'd2, 32'h1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_partial(5, 1'b0);
        @(negedge clk); reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mq.delete(); m_ovf = 0; m_perr = 0; m_irq_en = 0;
        cpu_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", rd, 32'h0); end
        cpu_read(2'd1, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h0); end
        cpu_read(2'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", rd, 32'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        send_frame(8'h2B, 1'b0, 1'b0, 1'b0); m_frame(8'h2B, 1'b1);
        cpu_read(2'd0, rd); exp_v = m_data_read();
        checks++; if (rd !== exp_v) begin failures++; $display("FAIL reset_next_frame got=%h exp=%h", rd, exp_v); end
    endtask

    task automatic test_good_frame();
        cpu_write(2'd2, 32'h1); m_irq_en = 1;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0); m_frame(8'h1C, 1'b1);
        checks++; if ((irq_lat >= 1 && irq_lat <= 10) !== 1'b1) begin failures++; $display("FAIL good_irq_latency got=%0d exp=1..10", irq_lat); end
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL good_status got=%h exp=%h", rd, m_status()); end
        checks++; if (irq !== m_irq()) begin failures++; $display("FAIL good_irq got=%b exp=%b", irq, m_irq()); end
        cpu_read(2'd0, rd); exp_v = m_data_read();
        checks++; if (rd !== exp_v) begin failures++; $display("FAIL good_data got=%h exp=%h", rd, exp_v); end
        checks++; if (irq !== m_irq()) begin failures++; $display("FAIL good_irq_drop got=%b exp=%b", irq, m_irq()); end
        cpu_read(2'd0, rd); exp_v = m_data_read();
        checks++; if (rd !== exp_v) begin failures++; $display("FAIL good_data_empty got=%h exp=%h", rd, exp_v); end
        cpu_write(2'd2, 32'h3);
        cpu_read(2'd2, rd);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ctrl_readback got=%h exp=%h", rd, 32'h1); end
    endtask

    task automatic test_bad_frames();
        for (int t = 0; t < 2; t++) begin
            send_frame(8'h1C, (t == 0), (t == 1), 1'b0); m_frame(8'h1C, 1'b0);
            cpu_read(2'd1, rd);
            checks++; if (rd !== m_status()) begin failures++; $display("FAIL bad%0d_status got=%h exp=%h", t, rd, m_status()); end
            cpu_read(2'd0, rd); exp_v = m_data_read();
            checks++; if (rd !== exp_v) begin failures++; $display("FAIL bad%0d_data got=%h exp=%h", t, rd, exp_v); end
            cpu_write(2'd1, 32'h8); m_perr = 0;
            cpu_read(2'd1, rd);
            checks++; if (rd !== m_status()) begin failures++; $display("FAIL bad%0d_w1c got=%h exp=%h", t, rd, m_status()); end
        end
    endtask

    task automatic test_overflow();
        cpu_write(2'd2, 32'h0); m_irq_en = 0;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b0); m_frame(8'(i), 1'b1);
        end
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL ovf_status got=%h exp=%h", rd, m_status()); end
        checks++; if (irq !== m_irq()) begin failures++; $display("FAIL ovf_irq got=%b exp=%b", irq, m_irq()); end
        for (int i = 0; i < 9; i++) begin
            cpu_read(2'd0, rd); exp_v = m_data_read();
            checks++; if (rd !== exp_v) begin failures++; $display("FAIL ovf_read%0d got=%h exp=%h", i, rd, exp_v); end
        end
        cpu_write(2'd1, 32'h4); m_ovf = 0;
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL ovf_clear got=%h exp=%h", rd, m_status()); end
    endtask

    task automatic test_timeout();
        send_partial(4, 1'b1);
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL to_status got=%h exp=%h", rd, m_status()); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0); m_frame(8'h5A, 1'b1);
        cpu_read(2'd0, rd); exp_v = m_data_read();
        checks++; if (rd !== exp_v) begin failures++; $display("FAIL to_next_frame got=%h exp=%h", rd, exp_v); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b0, 1'b0); m_frame(b, 1'b1);
        end
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL full_status got=%h exp=%h", rd, m_status()); end
        send_frame(8'hAB, 1'b0, 1'b0, 1'b1);
        exp_v = m_data_read(); m_frame(8'hAB, 1'b1);
        checks++; if (coinc_rd !== exp_v) begin failures++; $display("FAIL coinc_read got=%h exp=%h", coinc_rd, exp_v); end
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL coinc_status got=%h exp=%h", rd, m_status()); end
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read(2'd0, rd); exp_v = m_data_read();
            checks++; if (rd !== exp_v) begin failures++; $display("FAIL coinc_drain%0d got=%h exp=%h", i, rd, exp_v); end
        end
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b0, 1'b0); m_frame(b, 1'b1);
        end
        cpu_write(2'd2, 32'h2); mq.delete(); m_irq_en = 0;
        cpu_read(2'd1, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL flush_status got=%h exp=%h", rd, m_status()); end
        cpu_read(2'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL flush_data got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int op;
        bit bad, kind;
        logic [31:0] w;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1, 2: begin
                    b = 8'($urandom); bad = ($urandom_range(0, 4) == 0); kind = 1'($urandom_range(0, 1));
                    send_frame(b, bad & ~kind, bad & kind, 1'b0); m_frame(b, !bad);
                end
                3: begin
                    cpu_read(2'd0, rd); exp_v = m_data_read();
                    checks++; if (rd !== exp_v) begin failures++; $display("FAIL rnd%0d_data got=%h exp=%h", it, rd, exp_v); end
                end
                4: begin
                    w = 32'($urandom_range(0, 15));
                    cpu_write(2'd1, w);
                    if (w[2]) m_ovf = 0;
                    if (w[3]) m_perr = 0;
                end
                default: begin
                    w = 32'($urandom_range(0, 1));
                    cpu_write(2'd2, w); m_irq_en = w[0];
                end
            endcase
            cpu_read(2'd1, rd);
            checks++; if (rd !== m_status()) begin failures++; $display("FAIL rnd%0d_status got=%h exp=%h", it, rd, m_status()); end
            checks++; if (irq !== m_irq()) begin failures++; $display("FAIL rnd%0d_irq got=%b exp=%b", it, irq, m_irq()); end
        end
    endtask

    initial begin
        avl.s_cs_n = 1'b1; avl.s_read = 1'b0; avl.s_write = 1'b0;
        avl.s_address = 2'd0; avl.s_writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_overflow();
        test_timeout();
        test_full_push_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
